// File: rtl/dcompressor_mc.sv
// Multi-channel dynamic range compressor: time-interleaved channels share one
// 3-stage datapath, each channel keeps its own peak envelope.
module dcompressor_mc #(
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 2,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int ATT_SHIFT = 0,
    parameter int REL_SHIFT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_valid,
    input  logic [CH_W-1:0]          i_ch,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic [DATA_W-2:0]        i_threshold,
    input  logic [2:0]               i_ratio,
    input  logic                     i_bypass,
    output logic                     o_valid,
    output logic [CH_W-1:0]          o_ch,
    output logic signed [DATA_W-1:0] o_data
);

    localparam int              MAG_W   = DATA_W - 1;
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    logic [DATA_W-1:0] w_abs;
    logic [MAG_W-1:0]  w_mag;
    logic              w_ch_ok;

    logic              r1_valid;
    logic [CH_W-1:0]   r1_ch;
    logic              r1_sign;
    logic [MAG_W-1:0]  r1_mag;
    logic [DATA_W-1:0] r1_raw;
    logic [MAG_W-1:0]  r1_thr;
    logic [2:0]        r1_ratio;
    logic              r1_bypass;

    logic [MAG_W-1:0]  r_env [NUM_CH];
    logic [MAG_W-1:0]  w_env_cur;
    logic [MAG_W-1:0]  w_env_nxt;
    logic [MAG_W-1:0]  w_excess;
    logic [MAG_W-1:0]  w_red;

    logic              r2_valid;
    logic [CH_W-1:0]   r2_ch;
    logic              r2_sign;
    logic [MAG_W-1:0]  r2_mag;
    logic [DATA_W-1:0] r2_raw;
    logic [MAG_W-1:0]  r2_red;
    logic              r2_bypass;

    logic [MAG_W-1:0]  w_mag_o;
    logic [DATA_W-1:0] w_out;

    // Only a non-power-of-two channel count can present an out-of-range index.
    generate
        if ((1 << CH_W) > NUM_CH) begin : g_ch_chk
            assign w_ch_ok = (int'(i_ch) < NUM_CH);
        end else begin : g_ch_all
            assign w_ch_ok = 1'b1;
        end
    endgenerate

    // NOTE: every always_comb output is assigned first on all paths, so no latch is inferred.
    always_comb begin
        w_abs = i_data[DATA_W-1] ? (~i_data + 1'b1) : i_data;
        w_mag = w_abs[DATA_W-1] ? MAG_MAX : w_abs[MAG_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignment so all stages advance on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            o_valid  <= 1'b0;
            o_ch     <= '0;
            o_data   <= '0;
        end else begin
            r1_valid <= i_valid;
            r2_valid <= r1_valid;
            o_valid  <= r2_valid;
            if (r2_valid) begin
                o_ch   <= r2_ch;
                o_data <= w_out;
            end
        end
    end

    // NOTE: datapath registers are qualified by their valid bit and need no reset.
    always_ff @(posedge i_clk) begin
        if (i_valid) begin
            r1_ch     <= i_ch;
            r1_sign   <= i_data[DATA_W-1];
            r1_mag    <= w_mag;
            r1_raw    <= i_data;
            r1_thr    <= i_threshold;
            r1_ratio  <= i_ratio;
            r1_bypass <= i_bypass | ~w_ch_ok;
        end
        if (r1_valid) begin
            r2_ch     <= r1_ch;
            r2_sign   <= r1_sign;
            r2_mag    <= r1_mag;
            r2_raw    <= r1_raw;
            r2_red    <= w_red;
            r2_bypass <= r1_bypass;
        end
    end

    // The write lands on the same edge the next sample enters stage 2, so a
    // back-to-back sample on the same channel always reads the fresh envelope.
    always_comb begin
        w_env_cur = r_env[r1_ch];
        if (r1_mag > w_env_cur) begin
            w_env_nxt = w_env_cur + ((r1_mag - w_env_cur) >> ATT_SHIFT);
        end else begin
            w_env_nxt = w_env_cur - ((w_env_cur - r1_mag) >> REL_SHIFT);
        end
        w_excess = (w_env_nxt > r1_thr) ? (w_env_nxt - r1_thr) : '0;
        w_red    = w_excess - (w_excess >> r1_ratio);
    end

    // NOTE: the envelope store is reset explicitly; its content is state, not qualified data.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_env[i] <= '0;
            end
        end else if (r1_valid && !r1_bypass) begin
            r_env[r1_ch] <= w_env_nxt;
        end
    end

    always_comb begin
        w_mag_o = (r2_mag > r2_red) ? (r2_mag - r2_red) : '0;
        if (r2_bypass) begin
            w_out = r2_raw;
        end else if (r2_sign) begin
            w_out = '0 - {1'b0, w_mag_o};
        end else begin
            w_out = {1'b0, w_mag_o};
        end
    end

endmodule

// File: tb/tb_dcompressor_mc.sv
// Directed self-checking bench for dcompressor_mc: a 2-channel instance for the
// main behaviour and a 3-channel instance for the out-of-range channel case.
module tb_dcompressor_mc;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_valid;
    logic [0:0]  i_ch;
    logic [15:0] i_data;
    logic [14:0] i_threshold;
    logic [2:0]  i_ratio;
    logic        i_bypass;
    logic        o_valid;
    logic [0:0]  o_ch;
    logic [15:0] o_data;

    logic        v3;
    logic [1:0]  ch3;
    logic [15:0] d3;
    logic        ov3;
    logic [1:0]  och3;
    logic [15:0] od3;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        bit          v;
        logic [15:0] ch;
        logic [15:0] d;
        string       tag;
    } exp_t;

    exp_t        pipe [3];
    logic [15:0] last_d;
    logic [15:0] last_ch;

    localparam logic [14:0] T = 15'h4000;

    always #5 i_clk = ~i_clk;

    dcompressor_mc #(.DATA_W(16), .NUM_CH(2), .ATT_SHIFT(0), .REL_SHIFT(4)) u_dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_valid     (i_valid),
        .i_ch        (i_ch),
        .i_data      (i_data),
        .i_threshold (i_threshold),
        .i_ratio     (i_ratio),
        .i_bypass    (i_bypass),
        .o_valid     (o_valid),
        .o_ch        (o_ch),
        .o_data      (o_data)
    );

    dcompressor_mc #(.DATA_W(16), .NUM_CH(3), .ATT_SHIFT(0), .REL_SHIFT(4)) u_dut3 (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_valid     (v3),
        .i_ch        (ch3),
        .i_data      (d3),
        .i_threshold (T),
        .i_ratio     (3'd2),
        .i_bypass    (1'b0),
        .o_valid     (ov3),
        .o_ch        (och3),
        .o_data      (od3)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 3; i++) begin
            pipe[i].v   = 1'b0;
            pipe[i].ch  = '0;
            pipe[i].d   = '0;
            pipe[i].tag = "idle";
        end
    endtask

    // One clock: check what the sample driven three cycles ago produced, then drive the next one.
    task automatic cycle(input bit v, input logic ch, input logic [15:0] x,
                         input logic [14:0] thr, input logic [2:0] r, input bit byp,
                         input logic [15:0] exp_d, input string tag);
        @(negedge i_clk);
        if (pipe[2].v) begin
            check({pipe[2].tag, "_valid"}, {15'd0, o_valid}, 16'd1);
            check({pipe[2].tag, "_ch"}, {15'd0, o_ch}, pipe[2].ch);
            check({pipe[2].tag, "_data"}, o_data, pipe[2].d);
            last_d  = pipe[2].d;
            last_ch = pipe[2].ch;
        end else begin
            check("idle_valid", {15'd0, o_valid}, 16'd0);
            check("hold_data", o_data, last_d);
            check("hold_ch", {15'd0, o_ch}, last_ch);
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0].v   = v;
        pipe[0].ch  = {15'd0, ch};
        pipe[0].d   = exp_d;
        pipe[0].tag = tag;
        i_valid     = v;
        i_ch        = ch;
        i_data      = x;
        i_threshold = thr;
        i_ratio     = r;
        i_bypass    = byp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 16'h0000, T, 3'd2, 1'b0, 16'h0000, "idle");
        end
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_valid     = 1'b0;
        i_ch        = '0;
        i_data      = '0;
        i_threshold = T;
        i_ratio     = 3'd2;
        i_bypass    = 1'b0;
        v3          = 1'b0;
        ch3         = '0;
        d3          = '0;
        last_d      = '0;
        last_ch     = '0;
        clear_pipe();

        // Reset and idle
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", {15'd0, o_valid}, 16'd0);
        check("rst_data", o_data, 16'h0000);
        check("rst_ch", {15'd0, o_ch}, 16'd0);
        check("rst_valid3", {15'd0, ov3}, 16'd0);
        i_reset_n = 1'b1;
        idle(3);

        // Reset with three samples in flight: none may emerge
        cycle(1'b1, 1'b0, 16'h6000, T, 3'd2, 1'b0, 16'h4800, "flush_a");
        cycle(1'b1, 1'b1, 16'h2000, T, 3'd2, 1'b0, 16'h2000, "flush_b");
        @(negedge i_clk);
        i_reset_n = 1'b0;
        i_valid   = 1'b1;
        i_ch      = 1'b0;
        i_data    = 16'h7000;
        clear_pipe();
        last_d  = '0;
        last_ch = '0;
        @(negedge i_clk);
        check("flush_valid", {15'd0, o_valid}, 16'd0);
        check("flush_data", o_data, 16'h0000);
        i_reset_n = 1'b1;
        i_valid   = 1'b0;
        idle(4);

        // Below threshold, compression, forwarding, release
        cycle(1'b1, 1'b0, 16'h1000, T, 3'd2, 1'b0, 16'h1000, "below_thr");
        cycle(1'b1, 1'b0, 16'h6000, T, 3'd2, 1'b0, 16'h4800, "comp_pos");
        cycle(1'b1, 1'b0, 16'hA000, T, 3'd2, 1'b0, 16'hB800, "comp_fwd_neg");
        cycle(1'b1, 1'b0, 16'h0000, T, 3'd2, 1'b0, 16'h0000, "release_clamp");
        cycle(1'b1, 1'b0, 16'h4000, T, 3'd2, 1'b0, 16'h2DB8, "release_decay");

        // Channel isolation
        cycle(1'b1, 1'b0, 16'h6000, T, 3'd2, 1'b0, 16'h4800, "iso_ch0_a");
        cycle(1'b1, 1'b1, 16'h1000, T, 3'd2, 1'b0, 16'h1000, "iso_ch1");
        cycle(1'b1, 1'b0, 16'h6000, T, 3'd2, 1'b0, 16'h4800, "iso_ch0_b");
        idle(4);

        // Edge values; the bypassed 0x7000 on ch1 must not move env[1] off 0x1000
        cycle(1'b1, 1'b0, 16'h8000, 15'h7FFF, 3'd2, 1'b0, 16'h8001, "most_neg_sat");
        cycle(1'b1, 1'b1, 16'h7000, T, 3'd2, 1'b1, 16'h7000, "bypass_ch1");
        cycle(1'b1, 1'b1, 16'h5000, T, 3'd2, 1'b0, 16'h4400, "bypass_env_kept");
        cycle(1'b1, 1'b0, 16'h8000, 15'h7FFF, 3'd2, 1'b1, 16'h8000, "bypass_most_neg");
        cycle(1'b1, 1'b0, 16'h1234, 15'h0000, 3'd0, 1'b0, 16'h1234, "ratio0");
        cycle(1'b1, 1'b1, 16'h8000, 15'h0000, 3'd0, 1'b0, 16'h8001, "ratio0_most_neg");
        cycle(1'b1, 1'b0, 16'h7FFF, 15'h7FFF, 3'd7, 1'b0, 16'h7FFF, "thr_max");
        idle(4);

        // Three-channel instance: index 3 is out of range and passes as bypass
        @(negedge i_clk);
        v3 = 1'b1; ch3 = 2'd2; d3 = 16'h6000;
        @(negedge i_clk);
        ch3 = 2'd3;
        @(negedge i_clk);
        ch3 = 2'd2;
        @(negedge i_clk);
        v3 = 1'b0;
        check("nc3_ch2_a_valid", {15'd0, ov3}, 16'd1);
        check("nc3_ch2_a_ch", {14'd0, och3}, 16'd2);
        check("nc3_ch2_a_data", od3, 16'h4800);
        @(negedge i_clk);
        check("nc3_oor_valid", {15'd0, ov3}, 16'd1);
        check("nc3_oor_ch", {14'd0, och3}, 16'd3);
        check("nc3_oor_data", od3, 16'h6000);
        @(negedge i_clk);
        check("nc3_ch2_b_data", od3, 16'h4800);
        @(negedge i_clk);
        check("nc3_idle_valid", {15'd0, ov3}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dcompressor_mc.md
Name: dcompressor_mc

Overview:
- Parametrised multi-channel dynamic range compressor; successor to the single-channel registered passthrough compressor stage.
- Sits in the audio DSP chain between the sample source/filters and the output stage.
- Time-interleaved channels share one datapath. Each channel keeps its own envelope state.
- Per-channel peak envelope follower (shift-based attack/release) drives a shift-based gain computer (ratio 2^R:1 above threshold). Fixed 3-cycle valid pipeline, no backpressure.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- NUM_CH, 2: number of interleaved channels (>=1).
- CH_W, $clog2(NUM_CH) (min 1): channel index width.
- ATT_SHIFT, 0: attack coefficient, 2^-ATT_SHIFT. 0 = instant attack.
- REL_SHIFT, 4: release coefficient, 2^-REL_SHIFT.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous active-low reset
- i_valid  in  1  input sample strobe
- i_ch  in  CH_W  channel of input sample (< NUM_CH)
- i_data  in  DATA_W  signed input sample
- i_threshold  in  DATA_W-1  unsigned magnitude threshold
- i_ratio  in  3  ratio exponent R; ratio = 2^R:1, R=0 means 1:1
- i_bypass  in  1  bypass: pass sample delayed, no processing
- o_valid  out  1  output sample strobe
- o_ch  out  CH_W  channel of output sample
- o_data  out  DATA_W  signed output sample

Behaviour:
- Reset and clocking: i_clk drives all state; reset is i_reset_n, synchronous, active-low.
- Reset values: o_valid=0, o_ch=0, o_data=0, all pipeline valids=0, all NUM_CH envelopes=0.
- Reset mid-stream: in-flight samples are discarded, so o_valid=0 the cycle after reset is sampled.
- Handshake:
  - i_valid qualifies i_ch, i_data, i_threshold, i_ratio and i_bypass. All are captured per sample in stage 1.
  - Result appears with o_valid=1 exactly 3 cycles after the i_valid cycle.
  - A new sample may arrive every cycle.
  - o_data/o_ch hold their last value while o_valid=0.
- Stage 1:
  - mag = |i_data|, saturated: most-negative input gives mag = 2^(DATA_W-1)-1.
  - Register sign, mag, raw sample, channel and config.
- Stage 2, envelope update on the stored envelope env[ch]:
  - If mag > env: env' = env + ((mag-env) >> ATT_SHIFT).
  - Otherwise: env' = env - ((env-mag) >> REL_SHIFT).
  - env' is written back to env[ch] only when the stage is valid and bypass=0. Bypass samples leave the envelope untouched.
- Forwarding: back-to-back samples on the same channel must use the just-computed env' (read-after-write forwarding). No stale reads.
- Gain computer, also in stage 2, unsigned arithmetic of width DATA_W-1:
  - excess = (env' > thr) ? env'-thr : 0.
  - red = excess - (excess >> R).
- Stage 3:
  - mag_o = (mag > red) ? mag-red : 0 (clamp, no wrap).
  - o_data = sign ? -mag_o : mag_o.
  - If bypass was set: o_data = raw i_data, bit-exact, including the most-negative value.
- Envelope range: never exceeds 2^(DATA_W-1)-1; no overflow is possible with the above forms.
- Boundary cases:
  - i_ch >= NUM_CH: sample passes as bypass; no envelope write.
  - R=0: red=0, output = saturated-magnitude sample.
  - Threshold = max: no reduction ever.
- Config inputs may change on any sample. No retiming or smoothing of config.
- Channels are fully independent: a sample on ch A never alters env[B].

Test Plan:
Common setup: DATA_W=16, NUM_CH=2, ATT_SHIFT=0, REL_SHIFT=4.
1. Reset/idle: hold i_reset_n=0 for 2 cycles, then i_valid=0 -> o_valid=0, o_data=0x0000, o_ch=0. Assert reset with 3 samples in flight -> none emerge.
2. Below threshold: thr=0x4000, R=2, ch0 x=0x1000 -> o_valid 3 cycles later, o_data=0x1000, o_ch=0.
3. Compression plus forwarding: thr=0x4000, R=2.
   - ch0 x=0x6000 -> env=0x6000, red=0x1800, o_data=0x4800.
   - Next cycle, ch0 x=0xA000 -> o_data=0xB800.
4. Release: continuing from step 3, ch0 x=0x0000 -> env=0x5A00, red=0x1380, o_data=0x0000 (clamped). Then ch0 x=0x4000 -> env=0x5860, red=0x1248, o_data=0x2DB8.
5. Channel isolation: ch0 x=0x6000, then ch1 x=0x1000 (thr=0x4000, R=2) -> ch1 o_data=0x1000, o_ch=1. A following ch0 x=0x6000 -> 0x4800.
6. Edge values:
   - x=0x8000, thr=0x7FFF -> o_data=0x8001.
   - Same sample with i_bypass=1 -> o_data=0x8000, env unchanged.
   - R=0 with thr=0 -> o_data=x.
   - i_ch=3 (out of range, CH_W=1 aliased via i_ch width sweep at NUM_CH=3) -> bypass output.
